// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake carrying the program image into the boot loader.
// A byte transfers on any clock edge where byte_valid and byte_ready are both high.
interface imem_boot_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses count/data/checksum byte stream, writes little-endian words
// into instruction memory, and releases the core from reset only after a verified load.
module imem_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    imem_boot_loader_if.slave   bs,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst_n,
    output logic                load_done,
    output logic                load_err,
    output logic [CNT_W-1:0]    words_loaded
);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [1:0]         byte_idx_reg, byte_idx_next;
    logic [CNT_W-1:0]   word_idx_reg, word_idx_next;
    logic [7:0]         sum_reg, sum_next;
    logic [7:0]         lane_reg [0:2];
    logic [7:0]         lane_next [0:2];
    logic               imem_we_reg, imem_we_next;
    logic [ADDR_W-1:0]  imem_addr_reg, imem_addr_next;
    logic [31:0]        imem_wdata_reg, imem_wdata_next;
    logic               core_rst_n_reg, core_rst_n_next;
    logic               load_done_reg, load_done_next;
    logic               load_err_reg, load_err_next;
    logic [CNT_W-1:0]   words_reg, words_next;
    logic               accept;
    logic [CNT_W-1:0]   n_full;

    assign bs.byte_ready = RST && (state_reg == CNT_LO || state_reg == CNT_HI ||
                                   state_reg == DATA   || state_reg == CSUM);
    assign accept = bs.byte_valid && bs.byte_ready;
    assign n_full = CNT_W'({bs.byte_data, count_reg[7:0]});

    // Lower three bytes of a word are latched in place; the 4th byte goes straight to the write.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        assign lane_next[gi] = (accept && state_reg == DATA && byte_idx_reg == 2'(gi))
                               ? bs.byte_data : lane_reg[gi];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg      <= CNT_LO;
            count_reg      <= '0;
            byte_idx_reg   <= '0;
            word_idx_reg   <= '0;
            sum_reg        <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            core_rst_n_reg <= 1'b0;
            load_done_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
            words_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            byte_idx_reg   <= byte_idx_next;
            word_idx_reg   <= word_idx_next;
            sum_reg        <= sum_next;
            imem_we_reg    <= imem_we_next;
            imem_addr_reg  <= imem_addr_next;
            imem_wdata_reg <= imem_wdata_next;
            core_rst_n_reg <= core_rst_n_next;
            load_done_reg  <= load_done_next;
            load_err_reg   <= load_err_next;
            words_reg      <= words_next;
        end
    end

    // Partially assembled word bytes need no reset; they are always overwritten before use.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            lane_reg[i] <= lane_next[i];
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        byte_idx_next   = byte_idx_reg;
        word_idx_next   = word_idx_reg;
        sum_next        = sum_reg;
        imem_we_next    = 1'b0;
        imem_addr_next  = imem_addr_reg;
        imem_wdata_next = imem_wdata_reg;
        core_rst_n_next = core_rst_n_reg;
        load_done_next  = load_done_reg;
        load_err_next   = load_err_reg;
        words_next      = words_reg;
        if (accept) begin
            case (state_reg)
                CNT_LO: begin
                    count_next = CNT_W'(bs.byte_data);
                    sum_next   = sum_reg + bs.byte_data;
                    state_next = CNT_HI;
                end
                CNT_HI: begin
                    count_next    = n_full;
                    sum_next      = sum_reg + bs.byte_data;
                    byte_idx_next = '0;
                    word_idx_next = '0;
                    if (32'(n_full) > MAX_WORDS) begin
                        state_next    = ERR;
                        load_err_next = 1'b1;
                    end else if (n_full == '0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    sum_next      = sum_reg + bs.byte_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        imem_we_next    = 1'b1;
                        imem_addr_next  = word_idx_reg[ADDR_W-1:0];
                        imem_wdata_next = {bs.byte_data, lane_reg[2], lane_reg[1], lane_reg[0]};
                        words_next      = words_reg + 1'b1;
                        word_idx_next   = word_idx_reg + 1'b1;
                        if (word_idx_reg == count_reg - 1'b1) begin
                            state_next = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (bs.byte_data == sum_reg) begin
                        state_next      = DONE;
                        load_done_next  = 1'b1;
                        core_rst_n_next = 1'b1;
                    end else begin
                        state_next    = ERR;
                        load_err_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign core_rst_n   = core_rst_n_reg;
    assign load_done    = load_done_reg;
    assign load_err     = load_err_reg;
    assign words_loaded = words_reg;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: streams images, predicts writes into a
// scoreboard queue, and checks writes and completion flags against it.
module tb_imem_boot_loader;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_rst_n;
    logic               load_done;
    logic               load_err;
    logic [CNT_W-1:0]   words_loaded;

    always #5 CLK = ~CLK;

    imem_boot_loader_if bs ();

    imem_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bs           (bs.slave),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_total = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the next predicted write, including its cycle.
    always @(negedge CLK) begin : monitor
        wr_t e;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0d data=%08h cyc=%0d (expected addr=%0d data=%08h cyc=%0d)",
                         imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit throttle, input bit push,
                             input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int waited = 0;
        bit acc = 1'b0;
        if (throttle) begin
            repeat ($urandom_range(0, 2)) begin
                bs.byte_valid = 1'b0;
                bs.byte_data  = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        bs.byte_data  = b;
        bs.byte_valid = 1'b1;
        while (!acc && waited < 20) begin
            @(negedge CLK);
            acc = bs.byte_ready;
            if (acc && push) exp_q.push_back('{a, d, cyc + 1});
            @(posedge CLK); #1;
            waited++;
        end
        bs.byte_valid = 1'b0;
        if (!acc) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input int nbytes, input bit throttle);
        int n;
        bit fits;
        bit push;
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        n    = int'({stream[1], stream[0]});
        fits = (n <= (1 << ADDR_W));
        for (int i = 0; i < nbytes; i++) begin
            push = fits && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4 == 3);
            a = '0;
            d = '0;
            if (push) begin
                a = ADDR_W'((i - 2) / 4);
                d = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
            end
            send_byte(stream[i], throttle, push, a, d);
        end
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b0;
        @(negedge CLK);
        chk({tag, "_ready_in_rst"}, 32'(bs.byte_ready), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk({tag, "_we"},    32'(imem_we), 32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core"},  32'(core_rst_n), 32'd0);
        chk({tag, "_done"},  32'(load_done), 32'd0);
        chk({tag, "_err"},   32'(load_err), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
        chk({tag, "_ready"}, 32'(bs.byte_ready), 32'd1);
        exp_q.delete();
        @(posedge CLK); #1;
    endtask

    task automatic check_final(input string tag, input bit done, input bit err, input int words);
        @(negedge CLK);
        $display("%s: load_done=%0b load_err=%0b core_rst_n=%0b words_loaded=%0d",
                 tag, load_done, load_err, core_rst_n, words_loaded);
        chk({tag, "_done"},    32'(load_done), 32'(done));
        chk({tag, "_err"},     32'(load_err), 32'(err));
        chk({tag, "_core"},    32'(core_rst_n), 32'(done));
        chk({tag, "_words"},   32'(words_loaded), 32'(words));
        chk({tag, "_ready"},   32'(bs.byte_ready), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic offer_ignored(input string tag);
        bs.byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bs.byte_data = 8'($urandom);
            @(negedge CLK);
            chk({tag, "_ignored_ready"}, 32'(bs.byte_ready), 32'd0);
            @(posedge CLK); #1;
        end
        bs.byte_valid = 1'b0;
    endtask

    initial begin
        bs.byte_data  = 8'h00;
        bs.byte_valid = 1'b0;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset("rst0");

        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
        send_stream(stream.size(), 1'b0);
        check_final("nominal", 1'b1, 1'b0, 2);
        offer_ignored("nominal");
        check_final("nominal_hold", 1'b1, 1'b0, 2);

        do_reset("rst1");
        stream[10] = 8'h0A;
        send_stream(stream.size(), 1'b0);
        check_final("badsum", 1'b0, 1'b1, 2);
        offer_ignored("badsum");

        do_reset("rst2");
        stream = '{8'h01, 8'h04};
        send_stream(stream.size(), 1'b0);
        check_final("oversize", 1'b0, 1'b1, 0);
        offer_ignored("oversize");
        check_final("oversize_hold", 1'b0, 1'b1, 0);

        do_reset("rst3");
        stream = '{8'h00, 8'h00, 8'h00};
        send_stream(stream.size(), 1'b0);
        check_final("zero", 1'b1, 1'b0, 0);

        do_reset("rst4");
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
        send_stream(stream.size(), 1'b1);
        check_final("throttled", 1'b1, 1'b0, 2);

        do_reset("rst5");
        send_stream(7, 1'b0);
        @(negedge CLK);
        chk("midload_words_before", 32'(words_loaded), 32'd1);
        @(posedge CLK); #1;
        do_reset("midrst");
        send_stream(stream.size(), 1'b0);
        check_final("replay", 1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
